// File: rtl/instr_encoder_if.sv
// Field-tuple input bus and encoded-word output bus of the instruction encoder.
// The slave modport is the encoder; the master modport is the loader/consumer side.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields plus a full immediate into a
// 32-bit instruction word, tags it with a sequential address and buffers it in
// a small FIFO. Tuples that fail a legality check are consumed but dropped and
// raise a sticky error carrying the first error code.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_encoder_if.slave     bus,
    output logic               err,
    output logic [1:0]         err_code,
    input  logic               clr_err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // Bit placement of each format; opcode always lands in [6:0].
    function automatic logic [31:0] encode(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (fmt)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Legality check: 0 = ok, 1 = immediate out of range, 2 = misaligned
    // branch/jump target, 3 = illegal format. Higher codes take priority.
    function automatic logic [1:0] check(
        input logic [2:0]  fmt,
        input logic [31:0] imm
    );
        logic signed [31:0] s;
        logic [1:0]         c;
        s = imm;
        if (fmt > FMT_J) begin
            c = 2'd3;
        end else if (((fmt == FMT_B) || (fmt == FMT_J)) && imm[0]) begin
            c = 2'd2;
        end else begin
            case (fmt)
                FMT_I, FMT_S: c = ((s < -32'sd2048) || (s > 32'sd2047)) ? 2'd1 : 2'd0;
                FMT_B:        c = ((s < -32'sd4096) || (s > 32'sd4094)) ? 2'd1 : 2'd0;
                FMT_J:        c = ((s < -32'sd1048576) || (s > 32'sd1048574)) ? 2'd1 : 2'd0;
                FMT_U:        c = (imm[11:0] != 12'h000) ? 2'd1 : 2'd0;
                default:      c = 2'd0;
            endcase
        end
        return c;
    endfunction

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   addr_mem_q  [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic          full_s;
    logic          accept_s;
    logic          pop_s;
    logic          push_s;
    logic [1:0]    chk_code_s;
    logic [31:0]   enc_word_s;

    assign full_s        = (count_q == FULL_CNT);
    assign bus.in_ready  = !full_s;
    assign bus.out_valid = (count_q != (PW+1)'(0));
    assign bus.out_instr = instr_mem_q[rd_ptr_q];
    assign bus.out_addr  = addr_mem_q[rd_ptr_q];
    assign err           = err_q;
    assign err_code      = err_code_q;

    // Handshake decode, encoding and the legality check for the offered tuple.
    always_comb begin
        accept_s   = bus.in_valid && !full_s;
        pop_s      = bus.out_valid && bus.out_ready;
        chk_code_s = check(bus.in_fmt, bus.in_imm);
        enc_word_s = encode(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs1,
                            bus.in_rs2, bus.in_funct3, bus.in_funct7, bus.in_imm);
        push_s     = accept_s && (chk_code_s == 2'd0);
    end

    // Next-state for FIFO pointers, occupancy, address counter and error flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        addr_d     = addr_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            addr_d   = addr_q + 32'd4;
        end else begin
            wr_ptr_d = wr_ptr_q;
            addr_d   = addr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase

        // A new error is recorded when none is pending or when the pending one
        // is being cleared on the same edge; otherwise the first error stays.
        if (accept_s && (chk_code_s != 2'd0) && (!err_q || clr_err)) begin
            err_d      = 1'b1;
            err_code_d = chk_code_s;
        end else if (clr_err) begin
            err_d      = 1'b0;
            err_code_d = 2'd0;
        end else begin
            err_d      = err_q;
            err_code_d = err_code_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= BASE_ADDR;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= 32'h0000_0000;
                addr_mem_q[i]  <= 32'h0000_0000;
            end
        end else if (push_s) begin
            instr_mem_q[wr_ptr_q] <= enc_word_s;
            addr_mem_q[wr_ptr_q]  <= addr_q;
        end else begin
            instr_mem_q[wr_ptr_q] <= instr_mem_q[wr_ptr_q];
            addr_mem_q[wr_ptr_q]  <= addr_mem_q[wr_ptr_q];
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a table of directed vectors, hand
// sequences for full/error/reset corners and a randomized phase, all checked
// against a queue-based reference model built from the encoding rules.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err;
    logic [1:0] err_code;
    logic       clr_err = 1'b0;

    instr_encoder_if bus ();

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .err      (err),
        .err_code (err_code),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding using shifts and masks on the spec's immediate bits.
    function automatic logic [31:0] ref_enc(input logic [31:0] fmt, op, rd, rs1, rs2,
                                            f3, f7, imm);
        logic [31:0] regs;
        regs = (rs2 << 20) | (rs1 << 15) | (f3 << 12);
        case (fmt)
            0: return (f7 << 25) | regs | (rd << 7) | op;
            1: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            2: return (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | op;
            3: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | op;
            4: return (imm & 32'hFFFF_F000) | (rd << 7) | op;
            5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                      | (rd << 7) | op;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_code(input int fmt, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        if (fmt > 5) return 3;
        if ((fmt == 3 || fmt == 5) && (imm % 2 != 0)) return 2;
        case (fmt)
            1, 2: return (s < -2048 || s > 2047) ? 1 : 0;
            3:    return (s < -4096 || s > 4094) ? 1 : 0;
            5:    return (s < -(1 << 20) || s > (1 << 20) - 2) ? 1 : 0;
            4:    return ((imm % 4096) != 0) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_addr;
    logic        m_err;
    logic [1:0]  m_code;

    // Cycle monitor: compares DUT against the model, then advances the model.
    initial begin
        ent_t e;
        int   code;
        bit   pop;
        bit   acc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                m_addr = BASE;
                m_err  = 1'b0;
                m_code = 2'd0;
            end else begin
                chk("mon_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
                chk("mon_in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
                chk("mon_err", 32'(err), 32'(m_err));
                chk("mon_err_code", 32'(err_code), 32'(m_code));
                if (mq.size() != 0) begin
                    chk("mon_head_instr", bus.out_instr, mq[0].instr);
                    chk("mon_head_addr", bus.out_addr, mq[0].addr);
                end
                pop  = (mq.size() != 0) && bus.out_ready;
                acc  = bus.in_valid && (mq.size() < DEPTH);
                code = ref_code(int'(bus.in_fmt), bus.in_imm);
                if (pop) void'(mq.pop_front());
                if (acc && code == 0) begin
                    e.instr = ref_enc(32'(bus.in_fmt), 32'(bus.in_opcode), 32'(bus.in_rd),
                                      32'(bus.in_rs1), 32'(bus.in_rs2), 32'(bus.in_funct3),
                                      32'(bus.in_funct7), bus.in_imm);
                    e.addr  = m_addr;
                    mq.push_back(e);
                    m_addr  = m_addr + 32'd4;
                end
                if (acc && code != 0 && (!m_err || clr_err)) begin
                    m_err  = 1'b1;
                    m_code = 2'(code);
                end else if (clr_err) begin
                    m_err  = 1'b0;
                    m_code = 2'd0;
                end
            end
        end
    end

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_fmt    = 3'd0;
        bus.in_opcode = 7'h00;
        bus.in_rd     = 5'd0;
        bus.in_rs1    = 5'd0;
        bus.in_rs2    = 5'd0;
        bus.in_funct3 = 3'd0;
        bus.in_funct7 = 7'h00;
        bus.in_imm    = 32'h0;
        bus.out_ready = 1'b0;
        clr_err       = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        bus.in_fmt    = fmt;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
    endtask

    // Offer one tuple; called just after a rising edge, returns just after the accept edge.
    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        bit got;
        got = 1'b0;
        set_fields(fmt, op, rd, rs1, rs2, f3, f7, imm);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL drive_timeout: in_ready stayed %0d, required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [31:0] exp_a;
        int          cat;
        logic [2:0]  rf;

        tbl[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,          32'h0050_0093, 2'd0};
        tbl[1]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0,          32'h0020_81B3, 2'd0};
        tbl[2]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,          32'h0020_A423, 2'd0};
        tbl[3]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFC,  32'hFE20_8EE3, 2'd0};
        tbl[4]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h0010_00EF, 2'd0};
        tbl[5]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000,  32'h1234_52B7, 2'd0};
        tbl[6]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,       32'h7E00_0FE3, 2'd0};
        tbl[7]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800,  32'h8000_0093, 2'd0};
        tbl[8]  = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF0_0000,  32'h8000_006F, 2'd0};
        tbl[9]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h0,         2'd1};
        tbl[10] = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,          32'h0,         2'd2};
        tbl[11] = '{3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1,          32'h0,         2'd3};
        tbl[12] = '{3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1001,  32'h0,         2'd1};
        tbl[13] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000,  32'h0,         2'd1};
        tbl[14] = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFF_F7FF,  32'h0,         2'd1};

        idle();
        #2;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_instr", bus.out_instr, 32'h0);
        chk("reset_out_addr", bus.out_addr, 32'h0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_err_code", 32'(err_code), 32'd0);
        do_reset();

        // Table-driven vectors
        exp_a = BASE;
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].fmt, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                  tbl[i].f3, tbl[i].f7, tbl[i].imm);
            @(negedge clk);
            if (tbl[i].exp_code == 2'd0) begin
                chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
                chk($sformatf("vec%0d_instr", i), bus.out_instr, tbl[i].exp_instr);
                chk($sformatf("vec%0d_addr", i), bus.out_addr, exp_a);
                exp_a = exp_a + 32'd4;
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
                @(posedge clk); #1;
                bus.out_ready = 1'b0;
            end else begin
                chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd0);
                chk($sformatf("vec%0d_err", i), 32'(err), 32'd1);
                chk($sformatf("vec%0d_code", i), 32'(err_code), 32'(tbl[i].exp_code));
                @(posedge clk); #1;
                clr_err = 1'b1;
                @(posedge clk); #1;
                clr_err = 1'b0;
            end
        end

        // First error wins, clear, address not advanced by dropped tuples
        do_reset();
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);
        @(negedge clk);
        chk("err_seq_err", 32'(err), 32'd1);
        chk("err_seq_code1", 32'(err_code), 32'd1);
        @(posedge clk); #1;
        drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3);
        @(negedge clk);
        chk("err_seq_code_kept", 32'(err_code), 32'd1);
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        @(negedge clk);
        chk("err_seq_cleared", 32'(err), 32'd0);
        @(posedge clk); #1;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
        @(negedge clk);
        chk("err_seq_addr", bus.out_addr, BASE);
        chk("err_seq_instr", bus.out_instr, 32'h0050_0093);

        // Clear and new error on the same edge records the new error
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096);
        bus.out_ready = 1'b0;
        clr_err = 1'b1;
        drive(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
        clr_err = 1'b0;
        @(negedge clk);
        chk("clr_new_err_code", 32'(err_code), 32'd3);

        // Full boundary and in-order drain
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'h00, 32'(i));
        end
        @(negedge clk);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        set_fields(3'd1, 7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 32'd9);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("full_hold_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("drain_addr0", bus.out_addr, 32'd0);
        chk("full_pop_no_pass", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("drain_addr1", bus.out_addr, 32'd4);
        chk("after_pop_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("drain_addr%0d", k), bus.out_addr, 32'(4 * k));
        end
        @(negedge clk);
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // Reset mid-drain
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(3'd0, 7'h33, 5'(i), 5'd1, 5'd2, 3'd0, 7'h20, 32'h0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_instr", bus.out_instr, 32'h0);
        chk("async_rst_addr", bus.out_addr, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
        @(negedge clk);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_addr", bus.out_addr, BASE);

        // Randomized phase; the monitor checks every cycle
        @(posedge clk); #1;
        for (int n = 0; n < 400; n++) begin
            cat = $urandom_range(0, 9);
            rf  = (cat == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            set_fields(rf, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                       3'($urandom), 7'($urandom), 32'h0);
            case (cat % 4)
                0: bus.in_imm = $urandom;
                1: bus.in_imm = 32'($signed(12'($urandom)));
                2: bus.in_imm = 32'($signed(21'($urandom))) & 32'hFFFF_FFFE;
                default: bus.in_imm = $urandom & 32'hFFFF_F000;
            endcase
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            clr_err       = ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
        end
        idle();
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        chk("final_empty", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
